// File: rtl/bus_pkg.sv
// Shared bus definitions: source index map, widths and encoder FSM state encoding.
package bus_pkg;

   localparam int NUM_SRC = 24;
   localparam int SEL_W   = 5;

   localparam int R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3;
   localparam int R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
   localparam int R8  = 8,  R9  = 9,  R10 = 10, R11 = 11;
   localparam int R12 = 12, R13 = 13, R14 = 14, R15 = 15;
   localparam int HI     = 16;
   localparam int LO     = 17;
   localparam int ZHI    = 18;
   localparam int ZLO    = 19;
   localparam int RSVD   = 20;
   localparam int PC     = 21;
   localparam int MDR    = 22;
   localparam int INPORT = 23;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRIVE    = 2'd1,
      ST_CONFLICT = 2'd2
   } state_t;

endpackage

// File: rtl/prio_enc_24.sv
// Lowest-index-wins priority encoder with zero and multiple-set flags.
module prio_enc_24
   import bus_pkg::*;
#(
   parameter int N = NUM_SRC,
   parameter int W = SEL_W
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_zero,
   output logic         o_multi
);

   logic [N-1:0] w_low_cleared;

   always_comb begin
      o_idx = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = W'(i);
      end
   end

   assign w_low_cleared = i_vec & (i_vec - {{(N-1){1'b0}}, 1'b1});
   assign o_zero        = ~|i_vec;
   assign o_multi       = |w_low_cleared;

endmodule

// File: rtl/bus_encoder_32_to_5.sv
// Encodes one-hot bus drive enables into a registered mux select, flagging
// multi-driver conflicts and requests on the unpopulated source.
module bus_encoder_32_to_5
   import bus_pkg::*;
#(
   parameter int NUM_SRC_P = NUM_SRC,
   parameter int SEL_W_P   = SEL_W,
   parameter int RSVD_IDX  = RSVD,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [NUM_SRC_P-1:0] src_out,
   output logic [SEL_W_P-1:0]   select,
   output logic                 sel_valid,
   output logic                 conflict,
   output logic                 rsvd_hit,
   output logic [CNT_W-1:0]     conflict_count,
   output logic [1:0]           state
);

   logic [NUM_SRC_P-1:0] w_legal;
   logic [SEL_W_P-1:0]   w_idx;
   logic                 w_zero;
   logic                 w_multi;

   logic [SEL_W_P-1:0]   r_select;
   logic                 r_sel_valid;
   logic                 r_conflict;
   logic                 r_rsvd_hit;
   logic [CNT_W-1:0]     r_conflict_count;
   state_t               r_state;

   always_comb begin
      w_legal           = src_out;
      w_legal[RSVD_IDX] = 1'b0;
   end

   prio_enc_24 #(.N(NUM_SRC_P), .W(SEL_W_P)) u_prio (
      .i_vec   (w_legal),
      .o_idx   (w_idx),
      .o_zero  (w_zero),
      .o_multi (w_multi)
   );

   // Next state depends only on the request count; select holds when idle.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state          <= ST_IDLE;
         r_select         <= '0;
         r_sel_valid      <= 1'b0;
         r_conflict       <= 1'b0;
         r_rsvd_hit       <= 1'b0;
         r_conflict_count <= '0;
      end else begin
         r_rsvd_hit <= src_out[RSVD_IDX];
         if (w_zero) begin
            r_state     <= ST_IDLE;
            r_sel_valid <= 1'b0;
            r_conflict  <= 1'b0;
         end else if (w_multi) begin
            r_state     <= ST_CONFLICT;
            r_select    <= w_idx;
            r_sel_valid <= 1'b1;
            r_conflict  <= 1'b1;
            if (r_conflict_count != {CNT_W{1'b1}})
               r_conflict_count <= r_conflict_count + CNT_W'(1);
         end else begin
            r_state     <= ST_DRIVE;
            r_select    <= w_idx;
            r_sel_valid <= 1'b1;
            r_conflict  <= 1'b0;
         end
      end
   end

   assign select         = r_select;
   assign sel_valid      = r_sel_valid;
   assign conflict       = r_conflict;
   assign rsvd_hit       = r_rsvd_hit;
   assign conflict_count = r_conflict_count;
   assign state          = r_state;

endmodule

// File: tb/tb_bus_encoder_32_to_5.sv
// Randomised self-checking bench for bus_encoder_32_to_5 with a tiny bus mux model.
module tb_bus_encoder_32_to_5;

   logic        clk = 1'b0;
   logic        clr;
   logic [23:0] src_out;
   logic [4:0]  select;
   logic        sel_valid, conflict, rsvd_hit;
   logic [7:0]  conflict_count;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_sel, m_valid, m_conf, m_rsvd, m_cnt, m_state;

   logic [31:0] data [24];
   logic [31:0] bus_contents;

   bus_encoder_32_to_5 dut (
      .clk            (clk),
      .clr            (clr),
      .src_out        (src_out),
      .select         (select),
      .sel_valid      (sel_valid),
      .conflict       (conflict),
      .rsvd_hit       (rsvd_hit),
      .conflict_count (conflict_count),
      .state          (state)
   );

   always #5 clk = ~clk;

   // bus mux downstream: registers the selected source each edge
   always @(posedge clk) bus_contents <= data[select];

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_sel = 0; m_valid = 0; m_conf = 0; m_rsvd = 0; m_cnt = 0; m_state = 0;
   endtask

   task automatic model_edge(input logic [23:0] v);
      logic [23:0] legal, lowbit;
      int n;
      legal     = v;
      legal[20] = 1'b0;
      n         = $countones(legal);
      lowbit    = legal & (~legal + 24'd1);
      m_rsvd    = int'(v[20]);
      if (n == 0) begin
         m_state = 0; m_valid = 0; m_conf = 0;
      end else begin
         m_sel   = $clog2(lowbit);
         m_valid = 1;
         m_conf  = (n > 1) ? 1 : 0;
         m_state = (n > 1) ? 2 : 1;
         if (n > 1 && m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".select"},    select,         m_sel);
      chk({tag, ".sel_valid"}, sel_valid,      m_valid);
      chk({tag, ".conflict"},  conflict,       m_conf);
      chk({tag, ".rsvd_hit"},  rsvd_hit,       m_rsvd);
      chk({tag, ".count"},     conflict_count, m_cnt);
      chk({tag, ".state"},     state,          m_state);
   endtask

   task automatic step(input logic [23:0] v, input string tag);
      src_out = v;
      @(posedge clk);
      model_edge(v);
      #1;
      check_all(tag);
   endtask

   function automatic logic [23:0] rand_vec();
      logic [23:0] v;
      case ($urandom_range(0, 3))
         0: v = '0;
         1: v = 24'h1 << $urandom_range(0, 23);
         2: v = (24'h1 << $urandom_range(0, 23)) | (24'h1 << $urandom_range(0, 23));
         default: v = 24'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 24; i++) data[i] = 32'h1000_0000 + 32'(i);
      data[5] = 32'hDEADBEEF;
      clr = 1'b1;
      src_out = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all("reset");
      @(negedge clk) clr = 1'b0;

      // single drive then release
      step(24'h200000, "pc_drive");
      step(24'h000000, "pc_release");

      // conflict and saturation
      step(24'h000048, "conflict_first");
      for (int i = 0; i < 299; i++) step(24'h000048, "conflict_hold");
      chk("sat_count", conflict_count, 255);

      // reserved source
      step(24'h100000, "rsvd_only");
      step(24'h110000, "rsvd_hi");

      // back-to-back sources
      step(24'h000002, "b2b_r1");
      step(24'h800000, "b2b_inport");
      step(24'h040000, "b2b_zhi");
      step(24'h000000, "b2b_idle");

      // end-to-end through the mux model: R5 enable rises before edge N
      src_out = 24'h000020;
      @(posedge clk); model_edge(24'h000020);
      #1 chk("e2e_sel_n1", select, 5);
      @(posedge clk); model_edge(24'h000020);
      #1 chk("e2e_bus_n2", bus_contents, 32'hDEADBEEF);
      check_all("e2e_hold");

      // asynchronous reset mid-cycle after a request
      step(24'h000001, "pre_async");
      step(24'h000006, "pre_async_conf");
      @(negedge clk);
      #2 clr = 1'b1;
      model_reset();
      #1 check_all("async_reset");
      @(negedge clk) clr = 1'b0;
      step(24'h000101, "post_reset_conf");

      for (int i = 0; i < 400; i++) step(rand_vec(), "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
